// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - two-requester arbiter for the single dcache CPU port, one request outstanding
// Optional round-robin arbitration enabled by defining DCACHE_ARB_RR_EN (fixed port-0 priority otherwise).
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_op,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]                req_wstrb,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]                req_atom,
    output logic [1:0]                req_gnt,
    output logic [1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic [EXP_WIDTH-1:0]      resp_exp,
    output logic [ADDR_WIDTH-1:0]     resp_badv,
    output logic                      c_valid,
    output logic                      c_op,
    output logic [ADDR_WIDTH-1:0]     c_addr,
    output logic [3:0]                c_write_type,
    output logic [DATA_WIDTH-1:0]     c_wdata,
    output logic                      c_atom,
    input  logic                      c_data_valid,
    input  logic [DATA_WIDTH-1:0]     c_rdata,
    input  logic [EXP_WIDTH-1:0]      c_exp,
    input  logic [ADDR_WIDTH-1:0]     c_badv,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       owner;
    logic       cancel;
    logic [1:0] cand;
    logic       win;
    logic       done;
    logic [1:0] gnt;

    // A flush blocks the pipeline port from being considered at all this cycle.
    assign cand = {req_valid[1], req_valid[0] & ~flush};
    assign done = c_data_valid | (|c_exp);

`ifdef DCACHE_ARB_RR_EN
    logic rr;
    assign win = (cand == 2'b11) ? rr : ~cand[0];
`else
    assign win = ~cand[0];
`endif

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        case (state)
            IDLE: begin
                if (|cand) begin
                    gnt       = win ? 2'b10 : 2'b01;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant is combinational, so it is forced low while reset is asserted.
    assign req_gnt    = rstn ? gnt : 2'b00;
    assign c_valid    = (state == BUSY);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP && !cancel) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            owner        <= 1'b0;
            cancel       <= 1'b0;
            c_op         <= 1'b0;
            c_addr       <= '0;
            c_write_type <= 4'b0;
            c_wdata      <= '0;
            c_atom       <= 1'b0;
            resp_rdata   <= '0;
            resp_exp     <= '0;
            resp_badv    <= '0;
`ifdef DCACHE_ARB_RR_EN
            rr           <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|cand) begin
                        owner        <= win;
                        c_op         <= req_op[win];
                        c_addr       <= win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                        c_write_type <= win ? req_wstrb[7:4] : req_wstrb[3:0];
                        c_wdata      <= win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                        c_atom       <= req_atom[win];
`ifdef DCACHE_ARB_RR_EN
                        rr           <= ~win;
`endif
                    end
                end
                BUSY: begin
                    // The cache op is never aborted; a flushed pipeline access only loses its response.
                    if (flush && !owner) begin
                        cancel <= 1'b1;
                    end
                    if (done) begin
                        resp_rdata <= (c_op || (|c_exp)) ? '0 : c_rdata;
                        resp_exp   <= c_exp;
                        resp_badv  <= (|c_exp) ? c_badv : '0;
                    end
                end
                RESP: begin
                    cancel <= 1'b0;
                end
                default: begin
                    cancel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - directed and randomized bench with a transaction-level model of dcache_port_arbiter
module tb_dcache_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic [1:0]  req_atom;
    logic [1:0]  req_gnt;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic [6:0]  resp_exp;
    logic [31:0] resp_badv;
    logic        c_valid;
    logic        c_op;
    logic [31:0] c_addr;
    logic [3:0]  c_write_type;
    logic [31:0] c_wdata;
    logic        c_atom;
    logic        c_data_valid;
    logic [31:0] c_rdata;
    logic [6:0]  c_exp;
    logic [31:0] c_badv;
    logic        busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .req_atom(req_atom),
        .req_gnt(req_gnt), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exp(resp_exp), .resp_badv(resp_badv),
        .c_valid(c_valid), .c_op(c_op), .c_addr(c_addr), .c_write_type(c_write_type),
        .c_wdata(c_wdata), .c_atom(c_atom),
        .c_data_valid(c_data_valid), .c_rdata(c_rdata), .c_exp(c_exp), .c_badv(c_badv),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passes++;
    endtask

    // Transaction-level model: one outstanding request, its response one cycle after completion.
    bit        m_busy, m_resp, m_cancel, m_rr, m_owner;
    bit        m_op, m_atom;
    bit [31:0] m_addr, m_wd, m_rdata, m_badv;
    bit [3:0]  m_wt;
    bit [6:0]  m_exp;

    always @(negedge clk) begin
        bit v0, v1, w;
        logic [1:0] e_gnt, e_rv;
        if (!rstn) begin
            chk("rst_ctrl", {req_gnt, resp_valid, c_valid, busy, c_op, c_atom}, 64'd0);
            chk("rst_c_addr", c_addr, 64'd0);
            chk("rst_resp", {resp_rdata, resp_exp, resp_badv}, 64'd0);
            m_busy = 0; m_resp = 0; m_cancel = 0; m_rr = 0; m_owner = 0;
        end else begin
            v0 = req_valid[0] && !flush;
            v1 = req_valid[1];
`ifdef DCACHE_ARB_RR_EN
            w = (v0 && v1) ? m_rr : !v0;
`else
            w = !v0;
`endif
            chk("busy", busy, m_busy || m_resp);
            chk("c_valid", c_valid, m_busy);
            e_gnt = (!m_busy && !m_resp && (v0 || v1)) ? (w ? 2'b10 : 2'b01) : 2'b00;
            chk("req_gnt", req_gnt, e_gnt);
            if (m_busy) begin
                chk("c_fields", {c_op, c_atom, c_write_type, c_addr}, {m_op, m_atom, m_wt, m_addr});
                chk("c_wdata", c_wdata, m_wd);
            end
            e_rv = (m_resp && !m_cancel) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("resp_valid", resp_valid, e_rv);
            if (e_rv != 0) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_exp_badv", {resp_exp, resp_badv}, {m_exp, m_badv});
            end
            if (m_resp) begin
                m_resp = 0; m_cancel = 0;
            end else if (m_busy) begin
                if (flush && !m_owner) m_cancel = 1;
                if (c_data_valid || c_exp != 0) begin
                    m_rdata = (m_op || c_exp != 0) ? 32'd0 : c_rdata;
                    m_exp   = c_exp;
                    m_badv  = (c_exp != 0) ? c_badv : 32'd0;
                    m_busy  = 0;
                    m_resp  = 1;
                end
            end else if (v0 || v1) begin
                m_owner = w;
                m_op    = req_op[w];
                m_atom  = req_atom[w];
                m_addr  = req_addr[w*32 +: 32];
                m_wd    = req_wdata[w*32 +: 32];
                m_wt    = req_wstrb[w*4 +: 4];
                m_busy  = 1;
                m_rr    = !w;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wstrb = 0;
        req_wdata = 0; req_atom = 0; c_data_valid = 0; c_rdata = 0; c_exp = 0; c_badv = 0;
    endtask

    task automatic set_req(input int p, input bit op, input logic [31:0] addr, input logic [3:0] ws,
                           input logic [31:0] wd, input bit atom);
        req_valid[p] = 1'b1;
        req_op[p] = op;
        req_addr[p*32 +: 32] = addr;
        req_wstrb[p*4 +: 4] = ws;
        req_wdata[p*32 +: 32] = wd;
        req_atom[p] = atom;
    endtask

    task automatic do_reset();
        step();
        rstn = 0;
        clear_inputs();
        step();
        step();
        rstn = 1;
    endtask

`ifdef DCACHE_ARB_RR_EN
    localparam logic [3:0] T3_ORDER = 4'b1010;
`else
    localparam logic [3:0] T3_ORDER = 4'b0000;
`endif

    initial begin
        logic [1:0] g;
        logic [3:0] wins;
        int n;
        rstn = 0;
        clear_inputs();
        do_reset();

        // T1: port-0 read, completion three cycles after grant
        step(); set_req(0, 0, 32'h1000, 4'h0, 32'h0, 0);
        @(negedge clk); chk("t1_gnt", req_gnt, 2'b01);
        step(); req_valid = 0;
        @(negedge clk); chk("t1_cvalid_t1", {c_valid, c_addr}, {1'b1, 32'h1000});
        step();
        @(negedge clk); chk("t1_cvalid_t2", c_valid, 1);
        step(); c_data_valid = 1; c_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("t1_cvalid_t3", c_valid, 1);
        step(); c_data_valid = 0;
        @(negedge clk); chk("t1_resp", {resp_valid, resp_rdata}, {2'b01, 32'hDEADBEEF});
        step();
        @(negedge clk); chk("t1_idle", busy, 0);

        // T2: port-1 write, read data masked to zero
        do_reset();
        step(); set_req(1, 1, 32'h2000, 4'b0011, 32'h1234, 0);
        @(negedge clk); chk("t2_gnt", req_gnt, 2'b10);
        step(); req_valid = 0; c_data_valid = 1; c_rdata = 32'hFFFF_FFFF;
        @(negedge clk); chk("t2_cfields", {c_op, c_write_type, c_wdata}, {1'b1, 4'b0011, 32'h1234});
        step(); c_data_valid = 0;
        @(negedge clk); chk("t2_resp", {resp_valid, resp_rdata}, {2'b10, 32'h0});

        // T3: both ports requesting continuously
        do_reset();
        step(); set_req(0, 0, 32'h10, 0, 0, 0); set_req(1, 0, 32'h20, 0, 0, 0); c_data_valid = 1;
        n = 0; wins = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (req_gnt != 0) begin
                wins[n] = req_gnt[1];
                n++;
            end
            if (n < 4) step();
        end
        chk("t3_grants", n, 4);
        chk("t3_order", wins, T3_ORDER);

        // T4: flush during second busy cycle cancels the port-0 response
        do_reset();
        step(); set_req(0, 0, 32'h3000, 0, 0, 0);
        @(negedge clk); chk("t4_gnt", req_gnt, 2'b01);
        step(); req_valid = 0;
        step(); flush = 1;
        @(negedge clk); chk("t4_cvalid_flush", c_valid, 1);
        step(); flush = 0; c_data_valid = 1; c_rdata = 32'h77;
        @(negedge clk); chk("t4_cvalid_held", c_valid, 1);
        step(); c_data_valid = 0; set_req(1, 0, 32'h4000, 0, 0, 0);
        @(negedge clk); chk("t4_no_resp", {busy, resp_valid}, {1'b1, 2'b00});
        step();
        @(negedge clk); chk("t4_next_gnt", req_gnt, 2'b10);
        step(); req_valid = 0; c_data_valid = 1;
        step(); c_data_valid = 0;

        // T5: exception without data valid completes the access
        do_reset();
        step(); set_req(0, 0, 32'h5000, 0, 0, 0);
        step(); req_valid = 0; c_exp = 7'h08; c_badv = 32'h5; c_rdata = 32'hABCD;
        step(); c_exp = 0; c_badv = 0;
        @(negedge clk); chk("t5_resp", {resp_valid, resp_exp, resp_badv, resp_rdata},
                            {2'b01, 7'h08, 32'h5, 32'h0});
        step();
        @(negedge clk); chk("t5_idle", busy, 0);

        // T6: reset while busy, then a fresh request
        do_reset();
        step(); set_req(0, 0, 32'h6000, 0, 0, 0);
        step(); req_valid = 0;
        @(negedge clk); chk("t6_busy", busy, 1);
        step(); rstn = 0;
        #1 chk("t6_rst_now", {busy, c_valid, req_gnt, resp_valid}, 0);
        step(); rstn = 1;
        step(); set_req(1, 0, 32'h40, 0, 0, 0);
        @(negedge clk); chk("t6_gnt", req_gnt, 2'b10);
        step(); req_valid = 0; c_data_valid = 1; c_rdata = 32'h55;
        step(); c_data_valid = 0;
        @(negedge clk); chk("t6_resp", {resp_valid, resp_rdata}, {2'b10, 32'h55});

        // Randomized traffic checked by the model every cycle
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); g = req_gnt;
            step();
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && g[p]) req_valid[p] = 1'b0;
                if (!req_valid[p] && $urandom_range(0, 2) == 0)
                    set_req(p, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                            $urandom, 1'($urandom_range(0, 1)));
            end
            flush = ($urandom_range(0, 7) == 0);
            c_data_valid = ($urandom_range(0, 2) == 0);
            c_exp = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            c_rdata = $urandom;
            c_badv = $urandom;
        end
        clear_inputs();
        step(); step(); step();
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
